// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: multi-cycle A - B - Bin, one 4-bit slice per clock,
// LSB slice first, with a registered inter-slice carry and a valid/ready
// handshake on both sides.
// Optional build macro: SUB_SATURATE_EN clamps diff on signed overflow.
module nibble_serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [IDXW-1:0]       idx;
  logic                  carry;
  logic [N-1:0][3:0]     a_q;
  logic [N-1:0][3:0]     b_q;
  logic [N-1:0][3:0]     diff_q;

  logic [3:0]            as;
  logic [3:0]            nbs;
  logic [3:0]            g;
  logic [3:0]            p;
  logic [3:0]            sum_s;
  logic                  c1, c2, c3, c4;
  logic                  idx_last;
  logic                  ovf_c;
  logic [N-1:0][3:0]     diff_new;
  logic [WIDTH-1:0]      diff_fin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign idx_last  = (idx == IDXW'(N - 1));

  // Current slice: a + ~b + carry through a 4-bit generate/propagate lookahead
  always_comb begin
    as    = a_q[idx];
    nbs   = ~b_q[idx];
    g     = as & nbs;
    p     = as ^ nbs;
    c1    = g[0] | (p[0] & carry);
    c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & carry);
    sum_s = p ^ {c3, c2, c1, carry};

    diff_new      = diff_q;
    diff_new[idx] = sum_s;

    // Only meaningful on the last slice, where sum_s[3] is the result MSB
    ovf_c    = (a_q[N-1][3] != b_q[N-1][3]) && (sum_s[3] != a_q[N-1][3]);
    diff_fin = diff_new;
`ifdef SUB_SATURATE_EN
    if (ovf_c) begin
      diff_fin = {a_q[N-1][3], {(WIDTH-1){~a_q[N-1][3]}}};
    end
`endif
  end

  // Control FSM, operand capture, slice write-back and final flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= ~bin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= c4;
          if (idx_last) begin
            idx    <= '0;
            diff_q <= diff_fin;
            bout   <= ~c4;
            ovf    <= ovf_c;
            zero   <= (diff_fin == '0);
            state  <= DONE;
          end else begin
            idx    <= idx + IDXW'(1);
            diff_q <= diff_new;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
